axil_mstr_replayer: RTL
=======================

// Module: axil_mstr_replayer
// PURPOSE
// Replays a recorded AXI-Lite master stream (sda/ocl/bar1) into the CL during replay runs. It is the
// counterpart of the AXI-Lite master recorder. Each log entry holds the AW/W/AR handshakes recorded in
// one cycle. The block re-drives those handshakes on an AXI-Lite master port in recorded entry order.
// It always accepts B/R responses, and tracks outstanding transactions.
// PARAMETERS
// ADDR_W      32  AXI-Lite address width
// DATA_W      32  AXI-Lite data width (STRB_W = DATA_W/8)
// MAX_OUTST   4   max outstanding writes (AW sent, B pending) and, separately, max outstanding reads
// OUTST_W     3   width of outstanding counters; must hold MAX_OUTST
// PORTS
// clk              in   1       clock
// sync_rst_n       in   1       synchronous reset, active-low
// replay_en        in   1       enables acceptance of new log entries
// log_valid        in   1       log entry valid
// log_ready        out  1       log entry accepted when log_valid&log_ready
// log_chmask       in   3       {ar,w,aw}: channels present in the entry
// log_awaddr       in   ADDR_W  recorded AW address
// log_wdata        in   DATA_W  recorded W data
// log_wstrb        in   STRB_W  recorded W strobe
// log_araddr       in   ADDR_W  recorded AR address
// awvalid/awaddr   out  1/ADDR_W   AW channel to CL;   awready in 1
// wvalid/wdata/wstrb out 1/DATA_W/STRB_W  W channel;   wready  in 1
// bvalid in 1, bresp in 2, bready out 1              B channel
// arvalid/araddr   out  1/ADDR_W   AR channel to CL;   arready in 1
// rvalid in 1, rdata in DATA_W, rresp in 2, rready out 1  R channel
// wr_outstanding   out  OUTST_W  AW handshakes minus B handshakes
// rd_outstanding   out  OUTST_W  AR handshakes minus R handshakes
// entries_done     out  32       count of fully replayed entries (wraps at 2^32)
// err              out  1        sticky: response with zero outstanding
// BEHAVIOUR
// - Reset: all *valid outputs 0, pending mask 0, counters 0, err 0. bready=rready=1 from first cycle after reset.
// - Accept: the entry is latched into output regs; pend <= log_chmask; channel valid = pend bit.
//   Exception: awvalid/arvalid are additionally gated when wr_/rd_outstanding == MAX_OUTST.
// - Each pend bit clears on its channel's handshake; payload regs are held stable while valid (AXI rule).
// - Entry N+1 channels are never driven before all channels of entry N have handshaked.
// - log_ready = replay_en & (pend_next == 0).
//   - pend_next is the pend mask after this cycle's handshakes.
//   - Back-to-back entries therefore run at 1 entry/cycle when slaves are ready.
//   - There is a combinational path from awready/wready/arready to log_ready.
// - entries_done increments when pend transitions nonzero->0.
// - An entry with chmask=0 is accepted, counted in entries_done, and drives nothing.
// - Counters:
//   - wr_outstanding: +1 on AW handshake, -1 on B handshake; both in the same cycle leaves it unchanged.
//   - rd_outstanding: same scheme for AR/R.
//   - B or R with the counter at 0 and no same-cycle issue: counter stays 0, err <= 1.
// - replay_en deassert mid-entry: the held entry completes (valids never drop early); no new entry is accepted.
// - Response data (bresp/rresp/rdata) is consumed and discarded; divergence checking is out of scope.
// - Reset asserted mid-entry: the entry is dropped, valids are 0 next cycle, and counters clear.
// TESTING
// - Single {aw,w} entry, slaves ready -> awvalid&wvalid one cycle after accept; entries_done=1; B returns -> wr_outstanding 1->0.
// - Entry {aw,w} with awready held 0 for 3 cycles, wready=1 -> W completes first.
//   - awvalid/awaddr are stable across the 3 stall cycles; log_ready=0 until the AW handshake.
// - 5 AW-only entries, bvalid held 0, MAX_OUTST=4 -> awvalid low after 4th handshake; 1 B -> 5th AW issues.
// - 8 back-to-back AR entries, arready=1 -> 8 AR handshakes in 8 consecutive cycles; entries_done=8.
// - bvalid with wr_outstanding=0 -> err=1 and sticky; wr_outstanding stays 0.
// - replay_en drop mid-entry, then reset mid-entry -> the held entry finishes, then all valids and counters are 0 after reset.

Source files
------------

// File: rtl/axil_mstr_replayer.sv
// AXI-Lite master replayer: re-drives recorded AW/W/AR handshakes in log order on a master port,
// always accepts B/R responses and keeps outstanding-transaction counts.
module axil_mstr_replayer #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 4,
    parameter int OUTST_W   = 3,
    localparam int STRB_W   = DATA_W / 8
) (
    input  logic               clk,
    input  logic               sync_rst_n,
    input  logic               replay_en,
    input  logic               log_valid,
    output logic               log_ready,
    input  logic [2:0]         log_chmask,
    input  logic [ADDR_W-1:0]  log_awaddr,
    input  logic [DATA_W-1:0]  log_wdata,
    input  logic [STRB_W-1:0]  log_wstrb,
    input  logic [ADDR_W-1:0]  log_araddr,
    output logic               awvalid,
    output logic [ADDR_W-1:0]  awaddr,
    input  logic               awready,
    output logic               wvalid,
    output logic [DATA_W-1:0]  wdata,
    output logic [STRB_W-1:0]  wstrb,
    input  logic               wready,
    input  logic               bvalid,
    input  logic [1:0]         bresp,
    output logic               bready,
    output logic               arvalid,
    output logic [ADDR_W-1:0]  araddr,
    input  logic               arready,
    input  logic               rvalid,
    input  logic [DATA_W-1:0]  rdata,
    input  logic [1:0]         rresp,
    output logic               rready,
    output logic [OUTST_W-1:0] wr_outstanding,
    output logic [OUTST_W-1:0] rd_outstanding,
    output logic [31:0]        entries_done,
    output logic               err
);

    localparam logic [OUTST_W-1:0] OUTST_MAX = OUTST_W'(MAX_OUTST);

    // pend bits: {ar, w, aw} still owed for the held entry
    logic [2:0] pend;
    logic [2:0] pend_next;
    logic       rsp_rdy;
    logic       aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic       accept;
    logic       wr_underflow, rd_underflow;
    logic [1:0] done_inc;
    logic       unused_rsp;

    // A response with nothing outstanding and no same-cycle issue leaves the count at zero.
    function automatic logic [OUTST_W-1:0] step_cnt(input logic [OUTST_W-1:0] cnt,
                                                    input logic inc, input logic dec);
        if (inc && !dec)
            return cnt + 1'b1;
        if (dec && !inc && cnt != '0)
            return cnt - 1'b1;
        return cnt;
    endfunction

    assign awvalid = pend[0] && (wr_outstanding != OUTST_MAX);
    assign wvalid  = pend[1];
    assign arvalid = pend[2] && (rd_outstanding != OUTST_MAX);
    assign bready  = rsp_rdy;
    assign rready  = rsp_rdy;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign ar_hs = arvalid && arready;
    assign b_hs  = bvalid && bready;
    assign r_hs  = rvalid && rready;

    assign pend_next = pend & ~{ar_hs, w_hs, aw_hs};
    assign log_ready = replay_en && (pend_next == 3'b000);
    assign accept    = log_valid && log_ready;

    assign wr_underflow = b_hs && !aw_hs && (wr_outstanding == '0);
    assign rd_underflow = r_hs && !ar_hs && (rd_outstanding == '0);

    // An entry finishing and an empty entry being accepted can land in the same cycle.
    assign done_inc = {1'b0, (pend != 3'b000) && (pend_next == 3'b000)}
                    + {1'b0, accept && (log_chmask == 3'b000)};

    // Response payloads are intentionally discarded.
    assign unused_rsp = ^{bresp, rresp, rdata};

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            pend           <= 3'b000;
            rsp_rdy        <= 1'b0;
            wr_outstanding <= '0;
            rd_outstanding <= '0;
            entries_done   <= '0;
            err            <= 1'b0;
        end else begin
            pend           <= accept ? log_chmask : pend_next;
            rsp_rdy        <= 1'b1;
            wr_outstanding <= step_cnt(wr_outstanding, aw_hs, b_hs);
            rd_outstanding <= step_cnt(rd_outstanding, ar_hs, r_hs);
            entries_done   <= entries_done + {30'd0, done_inc};
            if (wr_underflow || rd_underflow)
                err <= 1'b1;
        end
    end

    // Payload only changes on accept, which cannot happen while any channel is still valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            awaddr <= log_awaddr;
            wdata  <= log_wdata;
            wstrb  <= log_wstrb;
            araddr <= log_araddr;
        end
    end

endmodule
